// File: rtl/alu_ctl_pkg.sv
// Shared types and control-line constants for the CB-prefix bit-operation
// micro-sequencer and the ALU control bundle it drives.
package alu_ctl_pkg;

    typedef enum logic [1:0] {
        NO_OE  = 2'd0,
        BS_OE  = 2'd1,
        SH_OE  = 2'd2,
        RES_OE = 2'd3
    } oe_t;

    typedef enum logic {
        NO_LD  = 1'b0,
        BUS_LD = 1'b1
    } ld_t;

    typedef enum logic [1:0] {
        NO_SH    = 2'd0,
        SH_LEFT  = 2'd1,
        SH_RIGHT = 2'd2,
        SH_ROT   = 2'd3
    } sh_t;

    typedef enum logic [1:0] {
        BOP_BIT  = 2'd0,
        BOP_RES  = 2'd1,
        BOP_SET  = 2'd2,
        BOP_RSVD = 2'd3
    } alu_bitop_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        OPER = 3'd2,
        EVAL = 3'd3,
        DONE = 3'd4
    } alu_seq_state_t;

    typedef struct packed {
        logic [2:0] bs;
        logic [7:0] op;
        sh_t        sh;
        oe_t        oe;
        ld_t        la;
        ld_t        lb;
        logic       r;
        logic       s;
        logic       v;
        logic       ne;
        logic       ci;
        logic       l;
        logic       h;
    } alu_line_t;

    localparam alu_line_t ALU_LINE_IDLE = '{
        bs: 3'd0, op: 8'd0, sh: NO_SH, oe: NO_OE, la: NO_LD, lb: NO_LD,
        r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0
    };

    // Function-bit words, ordered {r, s, v, ne, ci, l, h}; L1 = low-nibble pass, L2 = high-nibble pass.
    localparam logic [6:0] L1_BIT = 7'b0100110;
    localparam logic [6:0] L2_BIT = 7'b0100101;
    localparam logic [6:0] L1_RES = 7'b1100010;
    localparam logic [6:0] L2_RES = 7'b1100001;
    localparam logic [6:0] L1_SET = 7'b0000010;
    localparam logic [6:0] L2_SET = 7'b0000001;

    function automatic logic [6:0] fn_bits(input alu_bitop_t op, input logic second_pass);
        logic [6:0] v;
        case (op)
            BOP_BIT: v = second_pass ? L2_BIT : L1_BIT;
            BOP_RES: v = second_pass ? L2_RES : L1_RES;
            BOP_SET: v = second_pass ? L2_SET : L1_SET;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu_bitop_seq_if.sv
// Decoder-side request/response bundle and ALU-side control/result bundle.
interface alu_bitop_dec_if
    import alu_ctl_pkg::*;
();
    logic       req;
    alu_bitop_t op;
    logic [2:0] bsel;
    logic [7:0] operand;
    logic       ready;
    logic       done;
    logic [7:0] res;
    logic       res_we;
    logic [3:0] flags;
    logic [3:0] flags_we;

    modport master (
        output req, op, bsel, operand,
        input  ready, done, res, res_we, flags, flags_we
    );

    modport slave (
        input  req, op, bsel, operand,
        output ready, done, res, res_we, flags, flags_we
    );
endinterface

interface alu_ctl_if
    import alu_ctl_pkg::*;
();
    alu_line_t  alu_line;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;

    modport master (
        output alu_line,
        input  alu_result, alu_zero, alu_carry
    );

    modport slave (
        input  alu_line,
        output alu_result, alu_zero, alu_carry
    );
endinterface

// File: rtl/alu_bitop_lines.sv
// Pure combinational map from sequencer state and captured instruction
// fields to the ALU control bundle for that state.
module alu_bitop_lines
    import alu_ctl_pkg::*;
(
    input  alu_seq_state_t i_state,
    input  alu_bitop_t     i_op,
    input  logic [2:0]     i_bsel,
    input  logic [7:0]     i_operand,
    output alu_line_t      o_line
);

    logic [6:0] w_fn;

    // Start from the idle bundle and override only what each step needs.
    always_comb begin
        o_line = ALU_LINE_IDLE;
        w_fn   = 7'd0;
        case (i_state)
            SEL: begin
                o_line.bs = i_bsel;
                o_line.oe = BS_OE;
                o_line.lb = BUS_LD;
                o_line.la = NO_LD;
            end
            OPER: begin
                o_line.op = i_operand;
                o_line.sh = NO_SH;
                o_line.oe = SH_OE;
                o_line.la = BUS_LD;
                o_line.lb = NO_LD;
                w_fn      = fn_bits(i_op, 1'b0);
            end
            EVAL: begin
                o_line.la = NO_LD;
                o_line.lb = NO_LD;
                o_line.oe = RES_OE;
                w_fn      = fn_bits(i_op, 1'b1);
            end
            default: begin
                o_line = ALU_LINE_IDLE;
                w_fn   = 7'd0;
            end
        endcase
        {o_line.r, o_line.s, o_line.v, o_line.ne, o_line.ci, o_line.l, o_line.h} = w_fn;
    end

endmodule

// File: rtl/alu_bitop_seq.sv
// Micro-sequencer for BIT/RES/SET b,r: walks the ALU through bit-select load,
// operand load and result read-out, then presents write-back and flag enables.
module alu_bitop_seq
    import alu_ctl_pkg::*;
#(
    parameter bit BACK2BACK = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    alu_bitop_dec_if.slave  dec_if,
    alu_ctl_if.master       alu_if
);

    alu_seq_state_t r_state;
    alu_seq_state_t w_next_state;
    alu_bitop_t     r_op;
    alu_bitop_t     w_op_next;
    logic [2:0]     r_bsel;
    logic [2:0]     w_bsel_next;
    logic [7:0]     r_operand;
    logic [7:0]     w_operand_next;
    logic           w_can_accept;
    logic           w_accept;
    alu_line_t      w_line_next;
    alu_line_t      r_alu_line;

    logic           r_ready;
    logic           r_done;
    logic [7:0]     r_res;
    logic           r_res_we;
    logic [3:0]     r_flags;
    logic [3:0]     r_flags_we;

    // Accept window, next state and next capture values.
    always_comb begin
        w_can_accept   = (r_state == IDLE) || (BACK2BACK && (r_state == DONE));
        w_accept       = w_can_accept && dec_if.req && (dec_if.op != BOP_RSVD);
        w_next_state   = r_state;
        w_op_next      = r_op;
        w_bsel_next    = r_bsel;
        w_operand_next = r_operand;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SEL;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SEL:  w_next_state = OPER;
            OPER: w_next_state = EVAL;
            EVAL: w_next_state = DONE;
            DONE: begin
                if (w_accept) begin
                    w_next_state = SEL;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (w_accept) begin
            w_op_next      = dec_if.op;
            w_bsel_next    = dec_if.bsel;
            w_operand_next = dec_if.operand;
        end else begin
            w_op_next      = r_op;
            w_bsel_next    = r_bsel;
            w_operand_next = r_operand;
        end
    end

    // Lines are computed for the upcoming state so the registered bundle lines up with it.
    alu_bitop_lines u_lines (
        .i_state   (w_next_state),
        .i_op      (w_op_next),
        .i_bsel    (w_bsel_next),
        .i_operand (w_operand_next),
        .o_line    (w_line_next)
    );

    // State, captured instruction fields and registered ALU control bundle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_op       <= BOP_BIT;
            r_bsel     <= 3'd0;
            r_operand  <= 8'd0;
            r_alu_line <= ALU_LINE_IDLE;
        end else begin
            r_state    <= w_next_state;
            r_op       <= w_op_next;
            r_bsel     <= w_bsel_next;
            r_operand  <= w_operand_next;
            r_alu_line <= w_line_next;
        end
    end

    // Decoder-facing outputs; result and flags are sampled from the ALU on the EVAL->DONE edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_res      <= 8'd0;
            r_res_we   <= 1'b0;
            r_flags    <= 4'd0;
            r_flags_we <= 4'd0;
        end else begin
            r_ready <= (w_next_state == IDLE) || (BACK2BACK && (w_next_state == DONE));
            if (w_next_state == DONE) begin
                r_done <= 1'b1;
                r_res  <= alu_if.alu_result;
                if (r_op == BOP_BIT) begin
                    r_res_we   <= 1'b0;
                    r_flags    <= {alu_if.alu_zero, 1'b0, 1'b1, alu_if.alu_carry};
                    r_flags_we <= 4'b1110;
                end else begin
                    r_res_we   <= 1'b1;
                    r_flags    <= 4'd0;
                    r_flags_we <= 4'b0000;
                end
            end else begin
                r_done     <= 1'b0;
                r_res      <= 8'd0;
                r_res_we   <= 1'b0;
                r_flags    <= 4'd0;
                r_flags_we <= 4'd0;
            end
        end
    end

    assign dec_if.ready    = r_ready;
    assign dec_if.done     = r_done;
    assign dec_if.res      = r_res;
    assign dec_if.res_we   = r_res_we;
    assign dec_if.flags    = r_flags;
    assign dec_if.flags_we = r_flags_we;
    assign alu_if.alu_line = r_alu_line;

endmodule

// File: tb/tb_alu_bitop_seq.sv
// Bench: two sequencers (BACK2BACK=1 and 0), each driving a small nibble-serial ALU model.
module tb_alu_bitop_seq;
    import alu_ctl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_bitop_dec_if dec0 ();
    alu_ctl_if       alu0 ();
    alu_bitop_dec_if dec1 ();
    alu_ctl_if       alu1 ();

    alu_bitop_seq #(.BACK2BACK(1'b1)) dut0 (.i_clk(clk), .i_reset(reset), .dec_if(dec0), .alu_if(alu0));
    alu_bitop_seq #(.BACK2BACK(1'b0)) dut1 (.i_clk(clk), .i_reset(reset), .dec_if(dec1), .alu_if(alu1));

    // ALU model: B latches the bit-select mask, A the operand; low nibble computed in the l pass.
    function automatic logic [7:0] shift8(input logic [7:0] v, input sh_t sh);
        case (sh)
            NO_SH:    return v;
            SH_LEFT:  return {v[6:0], 1'b0};
            SH_RIGHT: return {1'b0, v[7:1]};
            default:  return {v[6:0], v[7]};
        endcase
    endfunction

    function automatic logic [7:0] alu_y(input alu_line_t ln, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] m;
        x = (ln.la == BUS_LD && ln.oe == SH_OE) ? shift8(ln.op, ln.sh) : a;
        m = ln.r ? ~b : b;
        return ln.s ? (x & m) : (x | m);
    endfunction

    logic [7:0] a0 = 8'd0, b0 = 8'd0, y0, a1 = 8'd0, b1 = 8'd0, y1;
    logic [3:0] lo0 = 4'd0, lo1 = 4'd0;

    assign y0              = alu_y(alu0.alu_line, a0, b0);
    assign alu0.alu_result = alu0.alu_line.h ? {y0[7:4], lo0} : {4'h0, y0[3:0]};
    assign alu0.alu_zero   = (alu0.alu_result == 8'd0);
    assign alu0.alu_carry  = alu0.alu_line.ci;
    assign y1              = alu_y(alu1.alu_line, a1, b1);
    assign alu1.alu_result = alu1.alu_line.h ? {y1[7:4], lo1} : {4'h0, y1[3:0]};
    assign alu1.alu_zero   = (alu1.alu_result == 8'd0);
    assign alu1.alu_carry  = alu1.alu_line.ci;

    always @(posedge clk) begin
        if (alu0.alu_line.lb == BUS_LD && alu0.alu_line.oe == BS_OE) b0 <= 8'd1 << alu0.alu_line.bs;
        if (alu0.alu_line.la == BUS_LD && alu0.alu_line.oe == SH_OE) a0 <= shift8(alu0.alu_line.op, alu0.alu_line.sh);
        if (alu0.alu_line.l) lo0 <= y0[3:0];
        if (alu1.alu_line.lb == BUS_LD && alu1.alu_line.oe == BS_OE) b1 <= 8'd1 << alu1.alu_line.bs;
        if (alu1.alu_line.la == BUS_LD && alu1.alu_line.oe == SH_OE) a1 <= shift8(alu1.alu_line.op, alu1.alu_line.sh);
        if (alu1.alu_line.l) lo1 <= y1[3:0];
    end

    typedef struct {
        alu_bitop_t op;
        logic [7:0] res;
        logic       z;
        int         acc;
    } exp_t;

    typedef struct {
        alu_bitop_t op;
        logic [2:0] b;
        logic [7:0] v;
        logic [7:0] er;
        logic       ez;
    } vec_t;

    exp_t       sb[$];
    int         checks = 0, errors = 0, ncyc = 0;
    int         done_cnt = 0, last_done = -100, done_gap = 0;
    int         d1_cnt = 0;
    int         d1_cyc [2];
    logic [7:0] d1_res [2];
    logic [3:0] d1_flg [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for dut0 plus done capture for dut1, all on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (reset) begin
            sb.delete();
        end else begin
            if (alu0.alu_line.oe == SH_OE || alu0.alu_line.oe == RES_OE) begin
                if (sb.size() == 0) chk("active_line_no_op", 32'(sb.size()), 32'd1);
                else chk("alu_carry", 32'(alu0.alu_carry), 32'(sb[0].op == BOP_BIT));
            end
            if (dec0.done) begin
                done_cnt++;
                done_gap  = ncyc - last_done;
                last_done = ncyc;
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(dec0.done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(ncyc - e.acc), 32'd4);
                    if (e.op == BOP_BIT) begin
                        chk("bit_res_we", 32'(dec0.res_we), 32'd0);
                        chk("bit_flags_we", 32'(dec0.flags_we), 32'hE);
                        chk("bit_flags_znh", 32'(dec0.flags[3:1]), 32'({e.z, 1'b0, 1'b1}));
                    end else begin
                        chk("res", 32'(dec0.res), 32'(e.res));
                        chk("res_we", 32'(dec0.res_we), 32'd1);
                        chk("flags_we", 32'(dec0.flags_we), 32'd0);
                    end
                end
            end else begin
                chk("we_without_done", 32'({dec0.res_we, dec0.flags_we}), 32'd0);
            end
            if (dec1.done) begin
                if (d1_cnt < 2) begin
                    d1_cyc[d1_cnt] = ncyc;
                    d1_res[d1_cnt] = dec1.res;
                    d1_flg[d1_cnt] = dec1.flags;
                end
                d1_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue0(input alu_bitop_t op, input logic [2:0] b, input logic [7:0] v,
                          input logic [7:0] er, input logic ez);
        int n;
        n = 0;
        dec0.req = 1'b1; dec0.op = op; dec0.bsel = b; dec0.operand = v;
        while (!dec0.ready && n < 20) begin tick(); n++; end
        if (!dec0.ready) chk("ready_timeout", 32'(dec0.ready), 32'd1);
        tick();
        sb.push_back('{op: op, res: er, z: ez, acc: ncyc});
        dec0.req = 1'b0; dec0.operand = ~v; dec0.bsel = b + 3'd1;
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while ((sb.size() != 0 || !dec0.ready) && n < 30) begin tick(); n++; end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    vec_t tbl [9];

    initial begin
        int n, dc;
        tbl[0] = '{BOP_BIT, 3'd3, 8'h08, 8'h08, 1'b0};
        tbl[1] = '{BOP_BIT, 3'd7, 8'h7F, 8'h00, 1'b1};
        tbl[2] = '{BOP_BIT, 3'd0, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{BOP_BIT, 3'd0, 8'hFF, 8'h01, 1'b0};
        tbl[4] = '{BOP_SET, 3'd5, 8'h00, 8'h20, 1'b0};
        tbl[5] = '{BOP_RES, 3'd0, 8'hFF, 8'hFE, 1'b0};
        tbl[6] = '{BOP_SET, 3'd7, 8'h55, 8'hD5, 1'b0};
        tbl[7] = '{BOP_RES, 3'd4, 8'hFF, 8'hEF, 1'b0};
        tbl[8] = '{BOP_BIT, 3'd6, 8'h40, 8'h40, 1'b0};

        dec0.req = 1'b0; dec0.op = BOP_BIT; dec0.bsel = 3'd0; dec0.operand = 8'd0;
        dec1.req = 1'b0; dec1.op = BOP_BIT; dec1.bsel = 3'd0; dec1.operand = 8'd0;
        repeat (3) tick();
        chk("rst_ready", 32'(dec0.ready), 32'd1);
        chk("rst_done", 32'(dec0.done), 32'd0);
        chk("rst_res", 32'(dec0.res), 32'd0);
        chk("rst_flags", 32'(dec0.flags), 32'd0);
        chk("rst_we", 32'({dec0.res_we, dec0.flags_we}), 32'd0);
        chk("rst_line", 32'(alu0.alu_line), 32'(ALU_LINE_IDLE));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            issue0(tbl[i].op, tbl[i].b, tbl[i].v, tbl[i].er, tbl[i].ez);
            drain0();
        end

        // Reserved op in IDLE is no request.
        dc = done_cnt;
        dec0.req = 1'b1; dec0.op = BOP_RSVD; dec0.bsel = 3'd2; dec0.operand = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rsvd_ready", 32'(dec0.ready), 32'd1);
        end
        dec0.req = 1'b0;
        repeat (5) tick();
        chk("rsvd_no_done", 32'(done_cnt), 32'(dc));

        // Requests raised in SEL/OPER/EVAL are ignored; operand already scrambled after accept.
        issue0(BOP_SET, 3'd2, 8'h00, 8'h04, 1'b0);
        dec0.req = 1'b1; dec0.op = BOP_RES; dec0.bsel = 3'd0; dec0.operand = 8'hFF;
        tick();
        tick();
        dec0.req = 1'b0;
        drain0();

        // BACK2BACK=1: held req, pulses 4 apart.
        dc = done_cnt;
        dec0.req = 1'b1; dec0.op = BOP_SET; dec0.bsel = 3'd1; dec0.operand = 8'h00;
        tick();
        sb.push_back('{op: BOP_SET, res: 8'h02, z: 1'b0, acc: ncyc});
        dec0.op = BOP_BIT; dec0.bsel = 3'd1; dec0.operand = 8'h02;
        n = 0;
        while (done_cnt == dc && n < 20) begin tick(); n++; end
        sb.push_back('{op: BOP_BIT, res: 8'h02, z: 1'b0, acc: ncyc});
        dec0.req = 1'b0;
        drain0();
        chk("b2b_gap", 32'(done_gap), 32'd4);

        // BACK2BACK=0: same pair, pulses 5 apart.
        dec1.req = 1'b1; dec1.op = BOP_SET; dec1.bsel = 3'd1; dec1.operand = 8'h00;
        tick();
        dec1.op = BOP_BIT; dec1.bsel = 3'd1; dec1.operand = 8'h02;
        n = 0;
        while (d1_cnt == 0 && n < 20) begin tick(); n++; end
        tick();
        dec1.req = 1'b0;
        n = 0;
        while (d1_cnt < 2 && n < 20) begin tick(); n++; end
        chk("nb2b_count", 32'(d1_cnt), 32'd2);
        chk("nb2b_gap", 32'(d1_cyc[1] - d1_cyc[0]), 32'd5);
        chk("nb2b_res", 32'(d1_res[0]), 32'h02);
        chk("nb2b_bit_z", 32'(d1_flg[1][3]), 32'd0);

        // Reset in OPER aborts with no done pulse.
        issue0(BOP_BIT, 3'd4, 8'h10, 8'h10, 1'b0);
        tick();
        chk("oper_reached", 32'(alu0.alu_line.oe), 32'(SH_OE));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_state", 32'(dut0.r_state), 32'(IDLE));
        chk("abort_ready", 32'(dec0.ready), 32'd1);
        chk("abort_line", 32'(alu0.alu_line), 32'(ALU_LINE_IDLE));
        chk("abort_done", 32'(dec0.done), 32'd0);
        dc = done_cnt;
        repeat (6) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(dc));

        issue0(BOP_RES, 3'd7, 8'hFF, 8'h7F, 1'b0);
        drain0();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
